muldiv_sched: RTL and testbench
===============================

Name: muldiv_sched

Overview:
- Multi-cycle sequencer for the HI/LO multiply/divide resource of the single-cycle 54-instruction CPU.
- Accepts one operation per control-unit request: multu, div, divu, mult, mthi or mtlo.
- Runs a 32-iteration shift-add multiply or restoring divide, and owns the HI/LO registers.
- Stalls the PC until the result is committed, then lets the instruction retire.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock. Single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  a multiply/divide instruction is present. Held high by the CPU while stalled.
- cmd  in  2  00 multu, 01 mult, 10 divu, 11 div.
- a  in  WIDTH  rs value: multiplicand or dividend.
- b  in  WIDTH  rt value: multiplier or divisor.
- wr_hi  in  1  mthi write strobe.
- wr_lo  in  1  mtlo write strobe.
- wdata  in  WIDTH  mthi/mtlo data.
- stall  out  1  freezes the PC and register-file write.
- done  out  1  one-cycle pulse when HI/LO is updated by a mul/div.
- div_zero  out  1  sticky flag: last divide had b==0. Cleared by the next accepted start.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: state IDLE; hi, lo, div_zero, done and the counter all 0; stall 0. Reset mid-operation aborts the operation with no HI/LO update.
- States: IDLE, RUN, FIX.
- IDLE -> RUN when start & ~done_r.
  - Latch |a| and |b| (signed cmds) or raw a and b (unsigned).
  - Latch sign_q = a[31]^b[31] and sign_r = a[31].
  - Clear accumulator; count = 0.
- RUN, one iteration per cycle:
  - Multiply: if multiplier LSB is 1, add multiplicand to the upper accumulator; shift right {acc, mplier}.
  - Divide: shift {rem, quo} left; trial-subtract divisor; keep the result and set quo LSB if non-negative.
  - count increments; RUN -> FIX when count == WIDTH-1.
- FIX: sign fixup, then write HI/LO at the end of the cycle; FIX -> IDLE; done_r set for one cycle.
  - mult: 64-bit product negated if sign_q; {hi, lo} = product.
  - div: quotient negated if sign_q; remainder negated if sign_r; lo = quotient, hi = remainder.
  - Divide by zero (b==0): lo = 32'hFFFFFFFF, hi = a unmodified, div_zero = 1, no sign fixup.
  - 0x80000000 / 0xFFFFFFFF (signed): lo = 0x80000000, hi = 0. No trap.
- stall = (IDLE & start & ~done_r) | RUN | FIX. stall is low in the done cycle so the instruction retires.
- done = done_r.
- Latency, start first seen at cycle 0: RUN cycles 1..32, FIX cycle 33, done and new hi/lo visible at cycle 34. stall is high for cycles 0..33.
- Back-to-back: a new start in the done cycle is ignored (done_r mask). The next instruction's start is accepted the following cycle.
- mthi/mtlo: in IDLE with no accepted start, wr_hi/wr_lo update hi/lo at the clock edge in the same cycle, zero stall.
  - wr_hi and wr_lo together: both update with wdata.
  - Accepted start has priority over wr_*; wr_* is dropped.
  - wr_* is ignored outside IDLE.
- a and b are sampled only on the IDLE->RUN transition; later changes have no effect.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: multiply RUN ends early once the remaining multiplier bits are all zero, shifting the accumulator into final position in FIX.
  - RUN lasts max(1, msb_index(|b|)+1) cycles.
  - Divide is unchanged at 32 cycles.
- Undefined: all operations take exactly 32 RUN cycles. No extra logic.

Test Plan:
- multu a=0xFFFFFFFF, b=0xFFFFFFFF, start held -> stall high cycles 0..33; done at 34; hi=0xFFFFFFFE, lo=0x00000001; stall low at 34.
- mult a=-7 (0xFFFFFFF9), b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=100, b=0 -> lo=0xFFFFFFFF, hi=100, div_zero=1; a following multu clears div_zero.
- wr_lo=1, wdata=0x1234 in IDLE -> lo=0x1234 next cycle, stall never high. wr_hi together with an accepted start -> hi unchanged until FIX.
- rst asserted at cycle 10 of a div -> next cycle IDLE, hi=lo=0, stall=0, no done pulse.
- With MULDIV_EARLY_OUT_EN: multu a=3, b=5 -> RUN cycles 1..3, FIX 4, done at 5, lo=15, hi=0. Without the macro -> done at 34.

Source files
------------

// File: rtl/muldiv_sched.sv
// muldiv_sched: multi-cycle sequencer for the HI/LO multiply/divide unit.
// Runs a WIDTH-iteration shift-add multiply or restoring divide on operand
// magnitudes, applies the sign fixup, and owns the HI/LO registers.
//
// Optional build macro MULDIV_EARLY_OUT_EN: a multiply leaves RUN as soon as
// the remaining multiplier bits are all zero. FIX then shifts the partial
// product into its final position.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo writes land here
// RUN   | one multiply/divide iteration per cycle
// FIX   | sign fixup and HI/LO commit
module muldiv_sched #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       cmd_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             wr_hi_i,
    input  logic             wr_lo_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             stall_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // acc: upper product half / partial remainder
    // low: multiplier (product low half shifts in) / dividend-quotient
    // opnd: multiplicand / divisor
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] low_q, low_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic             is_div_q, is_div_d;
    logic             sign_q, sign_d;
    logic             sign_r_q, sign_r_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             div_zero_q, div_zero_d;
    logic             done_q, done_d;

    logic               op_signed;
    logic               accept;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   rem_shift;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [CNT_W-1:0]   run_last;

`ifdef MULDIV_EARLY_OUT_EN
    logic [CNT_W-1:0] end_q, end_d;
    logic [CNT_W-1:0] msb_b;
    logic [CNT_W:0]   shamt;

    // Index of the highest set bit of the multiplier magnitude (0 when zero)
    always_comb begin
        msb_b = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (abs_b[i]) msb_b = CNT_W'(i);
        end
    end
`endif

    // Operand conditioning, iteration datapath and result fixup
    always_comb begin
        op_signed = cmd_i[0];
        accept    = start_i & ~done_q;
        abs_a     = (op_signed && a_i[WIDTH-1]) ? -a_i : a_i;
        abs_b     = (op_signed && b_i[WIDTH-1]) ? -b_i : b_i;

        mul_sum   = {1'b0, acc_q} + (low_q[0] ? {1'b0, opnd_q} : '0);

        // Shifted remainder can need WIDTH+1 bits, so compare wide but
        // subtract narrow: a kept difference is always below the divisor.
        rem_shift = {acc_q[WIDTH-2:0], low_q[WIDTH-1]};
        div_ge    = ({acc_q, low_q[WIDTH-1]} >= {1'b0, opnd_q});

`ifdef MULDIV_EARLY_OUT_EN
        shamt    = (CNT_W+1)'(WIDTH) - {1'b0, cnt_q};
        prod_raw = {acc_q, low_q} >> shamt;
        run_last = is_div_q ? CNT_W'(WIDTH-1) : end_q;
`else
        prod_raw = {acc_q, low_q};
        run_last = CNT_W'(WIDTH-1);
`endif
        prod_fix = sign_q   ? -prod_raw : prod_raw;
        quo_fix  = sign_q   ? -low_q    : low_q;
        rem_fix  = sign_r_q ? -acc_q    : acc_q;
    end

    // Next-state, datapath update and outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        low_d      = low_q;
        opnd_d     = opnd_q;
        a_raw_d    = a_raw_q;
        is_div_d   = is_div_q;
        sign_d     = sign_q;
        sign_r_d   = sign_r_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
        end_d      = end_q;
`endif
        stall_o    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    stall_o    = 1'b1;
                    state_d    = S_RUN;
                    cnt_d      = '0;
                    acc_d      = '0;
                    low_d      = cmd_i[1] ? abs_a : abs_b;
                    opnd_d     = cmd_i[1] ? abs_b : abs_a;
                    a_raw_d    = a_i;
                    is_div_d   = cmd_i[1];
                    sign_d     = op_signed & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    sign_r_d   = op_signed & a_i[WIDTH-1];
                    dz_d       = (b_i == '0);
                    div_zero_d = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
                    end_d      = msb_b;
`endif
                end else begin
                    if (wr_hi_i) hi_d = wdata_i;
                    if (wr_lo_i) lo_d = wdata_i;
                end
            end

            S_RUN: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (is_div_q) begin
                    if (div_ge) begin
                        acc_d = rem_shift - opnd_q;
                        low_d = {low_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = rem_shift;
                        low_d = {low_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    low_d = {mul_sum[0], low_q[WIDTH-1:1]};
                end
                if (cnt_q == run_last) state_d = S_FIX;
            end

            S_FIX: begin
                stall_o = 1'b1;
                state_d = S_IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
                if (is_div_q) begin
                    if (dz_q) begin
                        lo_d       = '1;
                        hi_d       = a_raw_q;
                        div_zero_d = 1'b1;
                    end else begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            low_q      <= '0;
            opnd_q     <= '0;
            a_raw_q    <= '0;
            is_div_q   <= 1'b0;
            sign_q     <= 1'b0;
            sign_r_q   <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
            end_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            low_q      <= low_d;
            opnd_q     <= opnd_d;
            a_raw_q    <= a_raw_d;
            is_div_q   <= is_div_d;
            sign_q     <= sign_d;
            sign_r_q   <= sign_r_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
`ifdef MULDIV_EARLY_OUT_EN
            end_q      <= end_d;
`endif
        end
    end

    assign done_o     = done_q;
    assign div_zero_o = div_zero_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench for muldiv_sched: directed cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_sched;

    localparam int WIDTH = 32;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic [1:0]        cmd_i;
    logic [WIDTH-1:0]  a_i;
    logic [WIDTH-1:0]  b_i;
    logic              wr_hi_i;
    logic              wr_lo_i;
    logic [WIDTH-1:0]  wdata_i;
    logic              stall_o;
    logic              done_o;
    logic              div_zero_o;
    logic [WIDTH-1:0]  hi_o;
    logic [WIDTH-1:0]  lo_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        m_dz;

    muldiv_sched #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .cmd_i      (cmd_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .wr_hi_i    (wr_hi_i),
        .wr_lo_i    (wr_lo_i),
        .wdata_i    (wdata_i),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .div_zero_o (div_zero_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Expected {div_zero, hi, lo} from plain integer arithmetic
    function automatic logic [64:0] ref_op(input logic [1:0] cmd, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (cmd)
            2'b00: begin
                p = {32'h0, a} * {32'h0, b};
                return {1'b0, p};
            end
            2'b01: begin
                p = sa * sb;
                return {1'b0, p};
            end
            2'b10: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
            default: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Number of RUN cycles the operation should take
    function automatic int run_len(input logic [1:0] cmd, input logic [31:0] b);
        logic [31:0] ab;
        int          msb;
        ab  = (cmd[0] && b[31]) ? -b : b;
        msb = 0;
        for (int i = 0; i < 32; i++) begin
            if (ab[i]) msb = i;
        end
        return (EARLY && !cmd[1]) ? msb + 1 : 32;
    endfunction

    // Issue one mul/div with start held until the done cycle. With keep set,
    // start stays high so the next call issues back-to-back.
    task automatic run_op(input string tag, input logic [1:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input bit wr_at_start, input bit keep);
        logic [64:0] exp;
        int          lat;
        int          cyc;
        int          hold_err;
        int          stall_err;
        bit          got;
        exp     = ref_op(cmd, a, b);
        lat     = run_len(cmd, b) + 2;
        start_i = 1'b1;
        cmd_i   = cmd;
        a_i     = a;
        b_i     = b;
        if (wr_at_start) begin
            wr_hi_i = 1'b1;
            wr_lo_i = 1'b1;
            wdata_i = $urandom;
        end
        #1;
        check_val({tag, ":stall_c0"}, {63'h0, stall_o}, 64'h1);
        tick;
        wr_hi_i   = 1'b0;
        wr_lo_i   = 1'b0;
        cyc       = 1;
        got       = 1'b0;
        hold_err  = 0;
        stall_err = 0;
        while (cyc < 200 && !got) begin
            if (done_o === 1'b1) begin
                got = 1'b1;
            end else begin
                if (stall_o !== 1'b1) stall_err++;
                if (hi_o !== m_hi || lo_o !== m_lo || div_zero_o !== 1'b0) hold_err++;
                a_i     = $urandom;
                b_i     = $urandom;
                wr_hi_i = 1'($urandom_range(0, 1));
                wr_lo_i = 1'($urandom_range(0, 1));
                wdata_i = $urandom;
                tick;
                cyc++;
            end
        end
        wr_hi_i = 1'b0;
        wr_lo_i = 1'b0;
        check_val({tag, ":done_seen"}, {63'h0, got}, 64'h1);
        check_val({tag, ":latency"}, 64'(cyc), 64'(lat));
        check_val({tag, ":stall_run"}, 64'(stall_err), 64'h0);
        check_val({tag, ":hold"}, 64'(hold_err), 64'h0);
        check_val({tag, ":stall_done"}, {63'h0, stall_o}, 64'h0);
        check_val({tag, ":hi"}, {32'h0, hi_o}, {32'h0, exp[63:32]});
        check_val({tag, ":lo"}, {32'h0, lo_o}, {32'h0, exp[31:0]});
        check_val({tag, ":div_zero"}, {63'h0, div_zero_o}, {63'h0, exp[64]});
        m_dz = exp[64];
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        tick;
        check_val({tag, ":done_pulse"}, {63'h0, done_o}, 64'h0);
        if (!keep) begin
            start_i = 1'b0;
            #1;
            check_val({tag, ":stall_idle"}, {63'h0, stall_o}, 64'h0);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          dones;
        logic [1:0]  rc;
        logic [31:0] ra;
        logic [31:0] rb;
        rst_i   = 1'b1;
        start_i = 1'b0;
        cmd_i   = 2'b00;
        a_i     = '0;
        b_i     = '0;
        wr_hi_i = 1'b0;
        wr_lo_i = 1'b0;
        wdata_i = '0;
        m_hi    = '0;
        m_lo    = '0;
        m_dz    = 1'b0;
        tick;
        tick;
        rst_i = 1'b0;
        #1;
        check_val("rst:hi", {32'h0, hi_o}, 64'h0);
        check_val("rst:lo", {32'h0, lo_o}, 64'h0);
        check_val("rst:div_zero", {63'h0, div_zero_o}, 64'h0);
        check_val("rst:done", {63'h0, done_o}, 64'h0);
        check_val("rst:stall", {63'h0, stall_o}, 64'h0);

        // mtlo alone
        wr_lo_i = 1'b1;
        wdata_i = 32'h1234;
        #1;
        check_val("mtlo:stall", {63'h0, stall_o}, 64'h0);
        tick;
        wr_lo_i = 1'b0;
        m_lo    = 32'h1234;
        check_val("mtlo:lo", {32'h0, lo_o}, 64'h1234);
        check_val("mtlo:hi", {32'h0, hi_o}, {32'h0, m_hi});

        // mthi and mtlo together
        wr_hi_i = 1'b1;
        wr_lo_i = 1'b1;
        wdata_i = $urandom;
        #1;
        check_val("mthilo:stall", {63'h0, stall_o}, 64'h0);
        tick;
        wr_hi_i = 1'b0;
        wr_lo_i = 1'b0;
        m_hi    = wdata_i;
        m_lo    = wdata_i;
        check_val("mthilo:hi", {32'h0, hi_o}, {32'h0, m_hi});
        check_val("mthilo:lo", {32'h0, lo_o}, {32'h0, m_lo});

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check_val("multu_max:hi_const", {32'h0, hi_o}, 64'hFFFF_FFFE);
        check_val("multu_max:lo_const", {32'h0, lo_o}, 64'h1);
        run_op("mult_neg", 2'b01, 32'hFFFF_FFF9, 32'd3, 1'b1, 1'b1);
        check_val("mult_neg:lo_const", {32'h0, lo_o}, 64'hFFFF_FFEB);
        run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        check_val("div_neg:lo_const", {32'h0, lo_o}, 64'hFFFF_FFFD);
        run_op("divu_zero", 2'b10, 32'd100, 32'd0, 1'b0, 1'b1);
        check_val("divu_zero:dz_const", {63'h0, div_zero_o}, 64'h1);
        run_op("multu_small", 2'b00, 32'd3, 32'd5, 1'b0, 1'b0);
        run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("div_zero_s", 2'b11, 32'h8000_0007, 32'd0, 1'b1, 1'b0);
        run_op("mult_zero", 2'b01, 32'h1234_5678, 32'd0, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            rc = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 9));
                2:       rb = -32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            run_op("rand", rc, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Leave the sticky flag set, then reset in the middle of a divide
        run_op("pre_rst", 2'b10, 32'd55, 32'd0, 1'b0, 1'b0);
        start_i = 1'b1;
        cmd_i   = 2'b11;
        a_i     = $urandom;
        b_i     = $urandom | 32'h1;
        for (int c = 0; c < 10; c++) tick;
        rst_i   = 1'b1;
        start_i = 1'b0;
        tick;
        rst_i = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        m_dz = 1'b0;
        check_val("midrst:hi", {32'h0, hi_o}, 64'h0);
        check_val("midrst:lo", {32'h0, lo_o}, 64'h0);
        check_val("midrst:stall", {63'h0, stall_o}, 64'h0);
        check_val("midrst:div_zero", {63'h0, div_zero_o}, 64'h0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            if (done_o !== 1'b0) dones++;
            tick;
        end
        check_val("midrst:no_done", 64'(dones), 64'h0);
        run_op("post_rst", 2'b00, 32'd7, 32'd6, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
